layer5_train_ctrl: RTL and testbench

//  Per-sample training sequencer for the 5-neuron learning layer (downstream consumer of its outputs).
//  - Accepts a labelled sample over a valid/ready handshake.
//  - Drives the layer's valid and learn strobes and captures the layer's 5 outputs.
//  - Computes the argmax prediction and builds the 5-wide expected_out target vector from the label.
//  - Reports per-sample results and keeps running accuracy counters.

---
 rtl/layer5_train_ctrl_pkg.sv | 26 ++
 rtl/layer5_train_ctrl_argmax5.sv | 23 ++
 rtl/layer5_train_ctrl.sv | 151 +++++++++++++++
 tb/tb_layer5_train_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer5_train_ctrl_pkg.sv
// Shared types and constants for the layer-5 training sequencer.
// zero2one_t is unsigned Q1.15: 16'h8000 == 1.0.
package layer5_train_ctrl_pkg;

   localparam int CLASS_W = 3;
   localparam int N_CLASS = 5;

   typedef logic [15:0] zero2one_t;
   typedef logic signed [15:0] frac_t;
   typedef zero2one_t [N_CLASS-1:0] z5_t;

   localparam zero2one_t ZERO2ONE_ONE  = 16'h8000;
   localparam zero2one_t ZERO2ONE_ZERO = 16'h0000;
   localparam zero2one_t TARGET_HI     = 16'h7333;
   localparam zero2one_t TARGET_LO     = 16'h0CCD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVAL,
      ST_SETTLE,
      ST_CAPTURE,
      ST_LEARN,
      ST_REPORT
   } l5_state_e;

endpackage

// File: rtl/layer5_train_ctrl_argmax5.sv
// Combinational 5-way argmax over zero2one_t values.
// Strict '>' scan from index 0, so ties resolve to the lowest index.
module argmax5
   import layer5_train_ctrl_pkg::*;
(
   input  z5_t                i_v,
   output logic [CLASS_W-1:0] o_idx
);

   zero2one_t w_best;

   always_comb begin
      w_best = i_v[0];
      o_idx  = '0;
      for (int i = 1; i < N_CLASS; i++) begin
         if (i_v[i] > w_best) begin
            w_best = i_v[i];
            o_idx  = CLASS_W'(i);
         end
      end
   end

endmodule

// File: rtl/layer5_train_ctrl.sv
// Per-sample training sequencer for the 5-neuron learning layer.
// LAYER5_SOFT_TARGET_EN: use TARGET_HI/TARGET_LO instead of 1.0/0.0 targets.
module layer5_train_ctrl
   import layer5_train_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CW            = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [CLASS_W-1:0] s_label,
   input  logic               s_train,
   output logic               nl_valid,
   output logic               nl_learn,
   input  z5_t                nl_out,
   output z5_t                nl_expected,
   output logic               r_valid,
   output logic [CLASS_W-1:0] r_pred,
   output logic               r_correct,
   output logic               r_label_err,
   input  logic               stat_clear,
   output logic [CW-1:0]      stat_samples,
   output logic [CW-1:0]      stat_correct,
   output logic               busy
);

`ifdef LAYER5_SOFT_TARGET_EN
   localparam zero2one_t T_HI = TARGET_HI;
   localparam zero2one_t T_LO = TARGET_LO;
`else
   localparam zero2one_t T_HI = ZERO2ONE_ONE;
   localparam zero2one_t T_LO = ZERO2ONE_ZERO;
`endif

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   l5_state_e          r_state;
   logic [SW-1:0]      r_cnt;
   logic [CLASS_W-1:0] r_label;
   logic               r_train;

   logic [CLASS_W-1:0] w_idx;
   logic [CLASS_W-1:0] w_pred;
   logic               w_lerr;
   logic               w_learn;
   logic               w_ok;
   logic               w_rep;
   z5_t                w_tgt;

   argmax5 u_argmax (
      .i_v   (nl_out),
      .o_idx (w_idx)
   );

   assign w_lerr  = r_label > CLASS_W'(N_CLASS - 1);
   assign w_learn = r_train && !w_lerr;
   // Direct CAPTURE->REPORT needs the live argmax; via LEARN it is in r_pred
   assign w_pred  = (r_state == ST_CAPTURE) ? w_idx : r_pred;
   assign w_ok    = !w_lerr && (w_pred == r_label);
   assign w_rep   = (r_state == ST_LEARN) ||
                    ((r_state == ST_CAPTURE) && !w_learn);
   assign busy    = r_state != ST_IDLE;

   always_comb begin
      w_tgt = '0;
      for (int i = 0; i < N_CLASS; i++) begin
         w_tgt[i] = (!w_lerr && r_label == CLASS_W'(i)) ? T_HI : T_LO;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_label     <= '0;
         r_train     <= 1'b0;
         s_ready     <= 1'b0;
         nl_valid    <= 1'b0;
         nl_learn    <= 1'b0;
         nl_expected <= '0;
         r_valid     <= 1'b0;
         r_pred      <= '0;
         r_correct   <= 1'b0;
         r_label_err <= 1'b0;
      end else begin
         nl_valid <= 1'b0;
         nl_learn <= 1'b0;
         r_valid  <= 1'b0;
         if (w_rep) begin
            r_valid     <= 1'b1;
            r_correct   <= w_ok;
            r_label_err <= w_lerr;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (!s_ready) begin
                  s_ready <= 1'b1;
               end else if (s_valid) begin
                  r_label  <= s_label;
                  r_train  <= s_train;
                  s_ready  <= 1'b0;
                  nl_valid <= 1'b1;
                  r_state  <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               r_cnt   <= SW'(SETTLE_CYCLES - 1);
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_cnt == '0) r_state <= ST_CAPTURE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            ST_CAPTURE: begin
               r_pred      <= w_idx;
               nl_expected <= w_tgt;
               if (w_learn) begin
                  nl_learn <= 1'b1;
                  r_state  <= ST_LEARN;
               end else begin
                  r_state  <= ST_REPORT;
               end
            end
            ST_LEARN: begin
               r_state <= ST_REPORT;
            end
            ST_REPORT: begin
               s_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_samples <= '0;
         stat_correct <= '0;
      end else if (stat_clear) begin
         stat_samples <= '0;
         stat_correct <= '0;
      end else if (w_rep) begin
         if (stat_samples != '1) stat_samples <= stat_samples + 1'b1;
         if (w_ok && stat_correct != '1) stat_correct <= stat_correct + 1'b1;
      end
   end

endmodule

// File: tb/tb_layer5_train_ctrl.sv
// Directed self-checking bench for layer5_train_ctrl (SETTLE=4, CW=4).
// Expected targets follow LAYER5_SOFT_TARGET_EN when defined.
module tb_layer5_train_ctrl;
   import layer5_train_ctrl_pkg::*;

`ifdef LAYER5_SOFT_TARGET_EN
   localparam logic [15:0] E_HI = 16'h7333;
   localparam logic [15:0] E_LO = 16'h0CCD;
`else
   localparam logic [15:0] E_HI = 16'h8000;
   localparam logic [15:0] E_LO = 16'h0000;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [2:0] s_label = '0;
   logic       s_train = 1'b0;
   logic       nl_valid;
   logic       nl_learn;
   z5_t        nl_out = '0;
   z5_t        nl_expected;
   logic       r_valid;
   logic [2:0] r_pred;
   logic       r_correct;
   logic       r_label_err;
   logic       stat_clear = 1'b0;
   logic [3:0] stat_samples;
   logic [3:0] stat_correct;
   logic       busy;

   always #5 clock = ~clock;

   layer5_train_ctrl #(.SETTLE_CYCLES(4), .CW(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_label      (s_label),
      .s_train      (s_train),
      .nl_valid     (nl_valid),
      .nl_learn     (nl_learn),
      .nl_out       (nl_out),
      .nl_expected  (nl_expected),
      .r_valid      (r_valid),
      .r_pred       (r_pred),
      .r_correct    (r_correct),
      .r_label_err  (r_label_err),
      .stat_clear   (stat_clear),
      .stat_samples (stat_samples),
      .stat_correct (stat_correct),
      .busy         (busy)
   );

   int total = 0;
   int bad   = 0;
   int lat, nv_cnt, nv_first, ln_cnt, ln_at, rdy_busy, rv_seen;
   logic [2:0] pred;
   logic corr, lerr;
   z5_t e_vec;

   task automatic chk(input string tag, input logic [95:0] obs,
                      input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic hs(input logic [2:0] lab, input logic tr, output bit ok);
      for (int k = 0; k < 20 && !s_ready; k++) step();
      ok = s_ready;
      if (!ok) begin
         chk("ready_timeout", 96'(0), 96'(1));
      end else begin
         s_label = lab;
         s_train = tr;
         s_valid = 1'b1;
         step();
         s_valid = 1'b0;
      end
   endtask

   task automatic run(input logic [2:0] lab, input logic tr, input int clr_at);
      bit ok;
      lat = 0; nv_cnt = 0; nv_first = 0; ln_cnt = 0; ln_at = 0; rdy_busy = 0;
      hs(lab, tr, ok);
      if (ok) begin
         for (int n = 1; n <= 40; n++) begin
            if (nl_valid) begin
               nv_cnt++;
               if (nv_first == 0) nv_first = n;
            end
            if (nl_learn) begin
               ln_cnt++;
               ln_at = n;
            end
            if (s_ready && busy) rdy_busy++;
            if (r_valid) begin
               lat  = n;
               pred = r_pred;
               corr = r_correct;
               lerr = r_label_err;
               break;
            end
            stat_clear = (n == clr_at);
            step();
         end
         stat_clear = 1'b0;
         if (lat == 0) chk("rvalid_timeout", 96'(0), 96'(1));
      end
   endtask

   initial begin
      // Test 1: reset
      repeat (3) @(posedge clock);
      #1;
      chk("rst_s_ready", 96'(s_ready), 96'(0));
      chk("rst_nl_valid", 96'(nl_valid), 96'(0));
      chk("rst_r_valid", 96'(r_valid), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_stats", 96'({stat_samples, stat_correct}), 96'(0));
      chk("rst_nl_exp", 96'(nl_expected), 96'(0));
      reset_n = 1'b1;
      step();
      chk("rst_ready_after", 96'(s_ready), 96'(1));

      // Test 2: eval only, label 2
      nl_out = {16'h0CCD, 16'h2666, 16'h6666, 16'h199A, 16'h0CCD};
      run(3'd2, 1'b0, 0);
      chk("t2_nv_cnt", 96'(nv_cnt), 96'(1));
      chk("t2_nv_first", 96'(nv_first), 96'(1));
      chk("t2_learn", 96'(ln_cnt), 96'(0));
      chk("t2_lat", 96'(lat), 96'(7));
      chk("t2_pred", 96'(pred), 96'(2));
      chk("t2_corr", 96'({corr, lerr}), 96'(2));
      chk("t2_stats", 96'({stat_samples, stat_correct}), 96'({4'd1, 4'd1}));
      chk("t2_rdy_busy", 96'(rdy_busy), 96'(0));
      step();
      chk("t2_rv_pulse", 96'(r_valid), 96'(0));
      chk("t2_idle_ready", 96'({busy, s_ready}), 96'(1));

      // Test 3: train, label 4, max at index 1
      nl_out = {16'h3333, 16'h2666, 16'h199A, 16'h7333, 16'h0CCD};
      run(3'd4, 1'b1, 0);
      e_vec = {E_HI, E_LO, E_LO, E_LO, E_LO};
      chk("t3_lat", 96'(lat), 96'(8));
      chk("t3_learn_cnt", 96'(ln_cnt), 96'(1));
      chk("t3_learn_at", 96'(ln_at), 96'(7));
      chk("t3_pred", 96'(pred), 96'(1));
      chk("t3_corr", 96'({corr, lerr}), 96'(0));
      chk("t3_nl_exp", 96'(nl_expected), 96'(e_vec));
      chk("t3_stats", 96'({stat_samples, stat_correct}), 96'({4'd2, 4'd1}));

      // Test 4a: tie, label 0
      nl_out = {5{16'h4000}};
      run(3'd0, 1'b0, 0);
      e_vec = {E_LO, E_LO, E_LO, E_LO, E_HI};
      chk("t4_tie_pred", 96'(pred), 96'(0));
      chk("t4_tie_corr", 96'(corr), 96'(1));
      chk("t4_tie_exp", 96'(nl_expected), 96'(e_vec));

      // Test 4b: label error with train requested
      nl_out = {16'h0CCD, 16'h7000, 16'h1000, 16'h2000, 16'h3000};
      run(3'd7, 1'b1, 0);
      e_vec = {5{E_LO}};
      chk("t4_err_flag", 96'({corr, lerr}), 96'(1));
      chk("t4_err_learn", 96'(ln_cnt), 96'(0));
      chk("t4_err_lat", 96'(lat), 96'(7));
      chk("t4_err_pred", 96'(pred), 96'(3));
      chk("t4_err_exp", 96'(nl_expected), 96'(e_vec));
      chk("t4_err_stats", 96'({stat_samples, stat_correct}), 96'({4'd4, 4'd2}));

      // Test 5: saturation at 15, then clear coincident with report
      nl_out = {16'h0CCD, 16'h2666, 16'h6666, 16'h199A, 16'h0CCD};
      for (int s = 0; s < 20; s++) run(3'd2, 1'b0, 0);
      chk("t5_sat", 96'({stat_samples, stat_correct}), 96'({4'd15, 4'd15}));
      run(3'd2, 1'b0, 6);
      chk("t5_clr_rv", 96'(lat), 96'(7));
      chk("t5_clr", 96'({stat_samples, stat_correct}), 96'(0));
      step();
      chk("t5_clr_hold", 96'({stat_samples, stat_correct}), 96'(0));

      // Test 6: reset during SETTLE
      run(3'd2, 1'b0, 0);
      chk("t6_pre", 96'({stat_samples, stat_correct}), 96'({4'd1, 4'd1}));
      begin
         bit ok;
         hs(3'd2, 1'b0, ok);
         step();
         step();
         chk("t6_busy_before", 96'(busy), 96'(1));
         #2 reset_n = 1'b0;
         #1;
         chk("t6_async", 96'({busy, s_ready, nl_valid, nl_learn}), 96'(0));
         chk("t6_stats_clr", 96'({stat_samples, stat_correct}), 96'(0));
         step();
         step();
         reset_n = 1'b1;
         rv_seen = 0;
         for (int n = 0; n < 15; n++) begin
            step();
            if (r_valid) rv_seen++;
         end
         chk("t6_no_rvalid", 96'(rv_seen), 96'(0));
      end
      run(3'd2, 1'b0, 0);
      chk("t6_next_lat", 96'(lat), 96'(7));
      chk("t6_next_pred", 96'({pred, corr}), 96'({3'd2, 1'b1}));
      chk("t6_next_stats", 96'({stat_samples, stat_correct}), 96'({4'd1, 4'd1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
